rns_conv_sched: RTL

- Round-robin scheduler that shares one binary-to-RNS converter for the moduli set (32, 31, 21, 5) among NREQ requesters.
- Accepts operands with valid/ready handshakes and issues one conversion per cycle to the converter.
- Tracks requester tags through the converter's fixed latency.
- Buffers results in an output FIFO, and uses credit-based issue so that a stalled consumer never loses a result.

---
 rtl/rns_conv_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rns_conv_sched.sv
// Round-robin scheduler sharing one binary-to-RNS converter among NREQ requesters.
// Optional statistics counters are enabled with the RNS_SCHED_STATS_EN macro.
module rns_conv_sched #(
  parameter int NREQ       = 4,
  parameter int DYN_SIZE   = 16,
  parameter int MAX_MOD    = 5,
  parameter int CONV_LAT   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DYN_SIZE-1:0]   req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       conv_en,
  output logic [DYN_SIZE-1:0]        conv_n,
  input  logic [4*MAX_MOD-1:0]       conv_res,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_W-1:0]           out_tag,
  output logic [4*MAX_MOD-1:0]       out_res,
  output logic                       busy
`ifdef RNS_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]         stat_grants,
  output logic [15:0]                stat_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RW = 4 * MAX_MOD;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  logic [TAG_W-1:0]    r_rr_ptr;
  logic                r_conv_en;
  logic [DYN_SIZE-1:0] r_conv_n;
  logic [TAG_W-1:0]    r_issue_tag;
  logic [CONV_LAT-1:0] r_pipe_v;
  logic [TAG_W-1:0]    r_pipe_tag [CONV_LAT];
  logic [TAG_W-1:0]    r_fifo_tag [FIFO_DEPTH];
  logic [RW-1:0]       r_fifo_res [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_fifo_count;
  logic [CW-1:0]       r_inflight;
  logic                r_busy;

  logic                w_found;
  logic [TAG_W-1:0]    w_win;
  logic [TAG_W-1:0]    w_next_ptr;
  logic [CW-1:0]       w_used;
  logic                w_can_grant;
  logic                w_grant;
  logic                w_push;
  logic                w_pop;
  logic [CW-1:0]       w_fifo_next;
  logic [CW-1:0]       w_inflight_next;
  logic [DYN_SIZE-1:0] w_operand;

  // First valid requester at or after the round-robin pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = TAG_W'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  assign out_valid = (r_fifo_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_push    = r_pipe_v[CONV_LAT-1];
  assign w_used    = r_fifo_count + r_inflight;
  // A pop this cycle returns its credit immediately.
  assign w_can_grant     = (w_used < DEPTH_C) || w_pop;
  assign w_grant         = w_found && w_can_grant && !reset;
  assign req_ready       = w_grant ? (NREQ'(1) << w_win) : '0;
  assign w_next_ptr      = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
  assign w_operand       = req_data[w_win*DYN_SIZE +: DYN_SIZE];
  assign w_fifo_next     = r_fifo_count + CW'(w_push) - CW'(w_pop);
  assign w_inflight_next = r_inflight + CW'(w_grant) - CW'(w_push);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_conv_en    <= 1'b0;
      r_conv_n     <= '0;
      r_issue_tag  <= '0;
      r_pipe_v     <= '0;
      for (int k = 0; k < CONV_LAT; k++) r_pipe_tag[k] <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      r_inflight   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_conv_en <= w_grant;
      if (w_grant) begin
        r_rr_ptr    <= w_next_ptr;
        r_conv_n    <= w_operand;
        r_issue_tag <= w_win;
      end
      // Tag pipe mirrors the converter latency so tags meet their results.
      r_pipe_v[0]   <= r_conv_en;
      r_pipe_tag[0] <= r_issue_tag;
      for (int k = 1; k < CONV_LAT; k++) begin
        r_pipe_v[k]   <= r_pipe_v[k-1];
        r_pipe_tag[k] <= r_pipe_tag[k-1];
      end
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;
      r_fifo_count <= w_fifo_next;
      r_inflight   <= w_inflight_next;
      r_busy       <= (w_fifo_next != '0) || (w_inflight_next != '0);
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_tag[r_wr_ptr] <= r_pipe_tag[CONV_LAT-1];
      r_fifo_res[r_wr_ptr] <= conv_res;
    end
  end

  assign conv_en = r_conv_en;
  assign conv_n  = r_conv_n;
  assign out_tag = out_valid ? r_fifo_tag[r_rd_ptr] : '0;
  assign out_res = out_valid ? r_fifo_res[r_rd_ptr] : '0;
  assign busy    = r_busy;

`ifdef RNS_SCHED_STATS_EN
  logic [15:0] r_stat_grants [NREQ];
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) r_stat_grants[i] <= '0;
      r_stat_stall <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_grant && (int'(w_win) == i) && (r_stat_grants[i] != 16'hFFFF))
          r_stat_grants[i] <= r_stat_grants[i] + 16'd1;
      end
      if ((|req_valid) && !w_can_grant && (r_stat_stall != 16'hFFFF))
        r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NREQ; i++) stat_grants[i*16 +: 16] = r_stat_grants[i];
  end
  assign stat_stall = r_stat_stall;
`endif

endmodule
